// File: rtl/hs_pkg.sv
// Shared types and helpers for the handshake round-robin arbiter.
package hs_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/hs_rr_pick.sv
// Combinational first-valid search over N requests, starting at start_i and wrapping modulo N.
module hs_rr_pick
  import hs_pkg::*;
#(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  output logic [N-1:0]   gnt_onehot_o,
  output logic [IDW-1:0] gnt_idx_o,
  output logic           any_o
);

  logic [IDW-1:0] idx;

  always_comb begin
    gnt_onehot_o = '0;
    gnt_idx_o    = '0;
    any_o        = 1'b0;
    idx          = '0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = IDW'((32'(start_i) + i) % N);
      if (!any_o && req_i[idx]) begin
        any_o             = 1'b1;
        gnt_idx_o         = idx;
        gnt_onehot_o[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/handshake_rr_arbiter.sv
// N-to-1 valid/ready round-robin arbiter with burst locking and a registered output slice.
// Optional HS_ARB_SRC_ID_EN adds src_id_o carrying the index of the requester behind each beat.
module handshake_rr_arbiter
  import hs_pkg::*;
#(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned BURST = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   valid_pre_i,
  input  logic [N*W-1:0] data_pre_i,
  output logic [N-1:0]   ready_pre_o,
  output logic           valid_post_o,
  output logic [W-1:0]   data_post_o,
  input  logic           ready_post_i
`ifdef HS_ARB_SRC_ID_EN
  ,
  output logic [$clog2(N)-1:0] src_id_o
`endif
);

  localparam int unsigned IDW = $clog2(N);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [7:0]     cnt_q, cnt_d;
  logic           valid_q, valid_d;
  logic [W-1:0]   data_q, data_d;

  logic           load;
  logic           owner_hold;
  logic           same_owner;
  logic           accept;
  logic           any;
  logic [IDW-1:0] start;
  logic [IDW-1:0] gnt_idx;
  logic [N-1:0]   gnt_onehot;

  assign load       = !valid_q || ready_post_i;
  // A valid owner keeps the grant; otherwise fall back to the rotating pointer.
  assign owner_hold = (state_q == LOCKED) && valid_pre_i[owner_q];
  assign start      = owner_hold ? owner_q : ptr_q;

  hs_rr_pick #(
    .N   (N),
    .IDW (IDW)
  ) u_pick (
    .req_i        (valid_pre_i),
    .start_i      (start),
    .gnt_onehot_o (gnt_onehot),
    .gnt_idx_o    (gnt_idx),
    .any_o        (any)
  );

  assign accept      = load && any && !rst;
  assign ready_pre_o = accept ? gnt_onehot : '0;
  assign same_owner  = (state_q == LOCKED) && (gnt_idx == owner_q);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    if (accept) begin
      if (same_owner && ((32'(cnt_q) + 32'd1) < BURST)) begin
        cnt_d = cnt_q + 8'd1;
      end else begin
        ptr_d = IDW'(rr_next(32'(gnt_idx), N));
        if ((BURST > 1) && !same_owner) begin
          state_d = LOCKED;
          owner_d = gnt_idx;
          cnt_d   = 8'd1;
        end else begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
    end
  end

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (accept) begin
      valid_d = 1'b1;
      for (int unsigned k = 0; k < N; k++) begin
        if (gnt_idx == IDW'(k)) begin
          data_d = data_pre_i[k*W +: W];
        end
      end
    end else if (load) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_post_o = valid_q;
  assign data_post_o  = data_q;

`ifdef HS_ARB_SRC_ID_EN
  logic [IDW-1:0] src_q, src_d;

  always_comb begin
    src_d = src_q;
    if (accept) begin
      src_d = gnt_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= '0;
    end else begin
      src_q <= src_d;
    end
  end

  assign src_id_o = src_q;
`endif

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// Self-checking bench: instance A (BURST=2) and instance B (BURST=1), table rows plus scoreboard.
module tb_handshake_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  a_valid, a_rdy, b_valid, b_rdy;
  logic [31:0] a_data, b_data;
  logic        a_vpost, b_vpost, a_rpost, b_rpost;
  logic [7:0]  a_dpost, b_dpost;
`ifdef HS_ARB_SRC_ID_EN
  logic [1:0]  a_src, b_src;
`endif
  logic        a_inc, b_inc;
  int          n_tests, n_fail;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] src;
  } beat_t;

  typedef struct {
    logic [3:0] valid;
    logic       rpost;
    logic [3:0] exp_rdy;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [1:0] exp_src;
  } vec_t;

  beat_t qa[$];
  beat_t qb[$];
  vec_t  vec[10];

  handshake_rr_arbiter #(.N(4), .W(8), .BURST(2)) u_dut_a (
    .clk          (clk),
    .rst          (rst),
    .valid_pre_i  (a_valid),
    .data_pre_i   (a_data),
    .ready_pre_o  (a_rdy),
    .valid_post_o (a_vpost),
    .data_post_o  (a_dpost),
    .ready_post_i (a_rpost)
`ifdef HS_ARB_SRC_ID_EN
    ,
    .src_id_o     (a_src)
`endif
  );

  handshake_rr_arbiter #(.N(4), .W(8), .BURST(1)) u_dut_b (
    .clk          (clk),
    .rst          (rst),
    .valid_pre_i  (b_valid),
    .data_pre_i   (b_data),
    .ready_pre_o  (b_rdy),
    .valid_post_o (b_vpost),
    .data_post_o  (b_dpost),
    .ready_post_i (b_rpost)
`ifdef HS_ARB_SRC_ID_EN
    ,
    .src_id_o     (b_src)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: score transferring beats at the falling edge, then advance senders whose
  // ready was seen.
  task automatic step();
    logic [3:0] ra, rb;
    beat_t e;
    @(negedge clk);
    ra = a_rdy;
    rb = b_rdy;
    chk("a_ready_onehot0", 32'($onehot0(a_rdy)), 1);
    chk("b_ready_onehot0", 32'($onehot0(b_rdy)), 1);
    if (a_vpost && a_rpost) begin
      if (qa.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL a_extra_beat: got data %0h, expected no beat", a_dpost);
      end else begin
        e = qa.pop_front();
        chk("a_beat_data", a_dpost, e.data);
`ifdef HS_ARB_SRC_ID_EN
        chk("a_beat_src", a_src, e.src);
`endif
      end
    end
    if (b_vpost && b_rpost) begin
      if (qb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b_extra_beat: got data %0h, expected no beat", b_dpost);
      end else begin
        e = qb.pop_front();
        chk("b_beat_data", b_dpost, e.data);
`ifdef HS_ARB_SRC_ID_EN
        chk("b_beat_src", b_src, e.src);
`endif
      end
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (a_inc && ra[k]) a_data[k*8 +: 8] = a_data[k*8 +: 8] + 8'd1;
      if (b_inc && rb[k]) b_data[k*8 +: 8] = b_data[k*8 +: 8] + 8'd1;
    end
  endtask

  task automatic reset_dut(input int n);
    rst = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_a_valid_post", a_vpost, 0);
      chk("rst_a_data_post", a_dpost, 0);
      chk("rst_a_ready_pre", a_rdy, 0);
      chk("rst_b_valid_post", b_vpost, 0);
      chk("rst_b_ready_pre", b_rdy, 0);
`ifdef HS_ARB_SRC_ID_EN
      chk("rst_a_src", a_src, 0);
`endif
    end
    rst = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    a_valid = 4'hF;
    a_data  = 32'h13121110;
    a_rpost = 1'b1;
    a_inc   = 1'b0;
    b_valid = 4'h0;
    b_data  = 32'h0;
    b_rpost = 1'b1;
    b_inc   = 1'b0;

    // All four valid, downstream always ready: 0,0,1,1,2,2,3,3,0 at one beat per cycle.
    vec[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 8'h00, 2'd0};
    vec[1] = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};
    vec[2] = '{4'hF, 1'b1, 4'b0010, 1'b1, 8'h10, 2'd0};
    vec[3] = '{4'hF, 1'b1, 4'b0010, 1'b1, 8'h11, 2'd1};
    vec[4] = '{4'hF, 1'b1, 4'b0100, 1'b1, 8'h11, 2'd1};
    vec[5] = '{4'hF, 1'b1, 4'b0100, 1'b1, 8'h12, 2'd2};
    vec[6] = '{4'hF, 1'b1, 4'b1000, 1'b1, 8'h12, 2'd2};
    vec[7] = '{4'hF, 1'b1, 4'b1000, 1'b1, 8'h13, 2'd3};
    vec[8] = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'h13, 2'd3};
    vec[9] = '{4'hF, 1'b1, 4'b0001, 1'b1, 8'h10, 2'd0};

    // Reset held 3 cycles with every requester valid.
    reset_dut(3);

    for (int j = 0; j < 9; j++) begin
      qa.push_back('{8'h10 + 8'((j / 2) % 4), 2'((j / 2) % 4)});
    end
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      a_valid = vec[i].valid;
      a_rpost = vec[i].rpost;
      #1;
      chk($sformatf("stream_ready_row%0d", i), a_rdy, vec[i].exp_rdy);
      chk($sformatf("stream_valid_row%0d", i), a_vpost, vec[i].exp_v);
      chk($sformatf("stream_data_row%0d", i), a_dpost, vec[i].exp_d);
`ifdef HS_ARB_SRC_ID_EN
      chk($sformatf("stream_src_row%0d", i), a_src, vec[i].exp_src);
`endif
    end
    a_valid = 4'h0;
    step();
    chk("stream_drained_valid", a_vpost, 0);
    chk("stream_queue_empty", qa.size(), 0);

    // Downstream backpressure while holding 0x21.
    a_inc = 1'b1;
    reset_dut(2);
    a_data[15:8] = 8'h21;
    a_valid      = 4'b0010;
    a_rpost      = 1'b0;
    qa.push_back('{8'h21, 2'd1});
    qa.push_back('{8'h22, 2'd1});
    #1;
    chk("bp_first_ready", a_rdy, 4'b0010);
    step();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_hold_valid", a_vpost, 1);
      chk("bp_hold_data", a_dpost, 8'h21);
      chk("bp_hold_ready", a_rdy, 4'b0000);
      step();
    end
    a_rpost = 1'b1;
    #1;
    chk("bp_release_ready", a_rdy, 4'b0010);
    chk("bp_release_data", a_dpost, 8'h21);
    step();
    a_valid = 4'h0;
    #1;
    chk("bp_next_data", a_dpost, 8'h22);
    step();
    #1;
    chk("bp_drained_valid", a_vpost, 0);
    chk("bp_queue_empty", qa.size(), 0);

    // Burst break: 2 alone for one beat, then 2 and 3 together -> 2,2,3,3,2.
    reset_dut(2);
    a_data[23:16] = 8'h30;
    a_data[31:24] = 8'h40;
    a_valid       = 4'b0100;
    a_rpost       = 1'b1;
    qa.push_back('{8'h30, 2'd2});
    qa.push_back('{8'h31, 2'd2});
    qa.push_back('{8'h40, 2'd3});
    qa.push_back('{8'h41, 2'd3});
    qa.push_back('{8'h32, 2'd2});
    step();
    a_valid = 4'b1100;
    repeat (4) step();
    a_valid = 4'h0;
    step();
    step();
    #1;
    chk("burst_queue_empty", qa.size(), 0);
    chk("burst_drained_valid", a_vpost, 0);

    // BURST=1 with requesters 1 and 3 and random downstream stalls: strict alternation.
    reset_dut(2);
    b_inc   = 1'b1;
    b_data  = 32'h80000000;
    b_valid = 4'b1010;
    for (int j = 0; j < 128; j++) begin
      qb.push_back('{8'(j), 2'd1});
      qb.push_back('{8'h80 + 8'(j), 2'd3});
    end
    for (int i = 0; i < 200; i++) begin
      b_rpost = 1'($urandom_range(0, 1));
      step();
    end
    b_valid = 4'h0;
    b_rpost = 1'b1;
    step();
    step();
    #1;
    chk("rr1_enough_beats", 32'(qb.size() <= 216), 1);
    chk("rr1_drained_valid", b_vpost, 0);
    qb.delete();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
N-to-1 valid/ready arbiter. It shares one downstream handshake channel, such as a Handshake_Type1 bridge or a Handshake_Receiver, between N upstream senders. Arbitration is round-robin with optional burst locking. The output stage is a single registered slice with full throughput.

Parameters:
N, 4, number of requesters (2..16)
W, 8, data width per requester
BURST, 2, max consecutive accepts granted to one requester before forced rotation (1..255; 1 = pure round-robin)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
valid_pre_i  in  N  per-requester valid
data_pre_i  in  N*W  per-requester data, requester k at bits [k*W +: W]
ready_pre_o  out  N  per-requester ready, at most one bit high
valid_post_o  out  1  output valid (registered)
data_post_o  out  W  output data (registered)
ready_post_i  in  1  downstream ready

Behaviour:
- Reset (rst=1 at a clk edge):
  - valid_post_o=0, data_post_o=0
  - rr pointer=0, burst count=0, FSM=IDLE
  - ready_pre_o=0 combinationally while rst=1
  - Reset mid-transfer drops any held output beat; no recovery of that beat.
- Slice load enable: load = !valid_post_o || ready_post_i (combinational; ready passes through).
- Grant selection (combinational):
  - IDLE: first k with valid_pre_i[k], searching k = ptr, ptr+1, ... mod N.
  - LOCKED(owner): owner if valid_pre_i[owner]; otherwise the round-robin search as in IDLE.
- Accept conditions:
  - ready_pre_o[g] = load && valid_pre_i[g] for the selected g; all other bits 0.
  - An accept occurs when ready_pre_o[g]=1. On that edge: data_post_o <= data_pre_i[g], valid_post_o <= 1.
  - When load=1 and no requester is valid: valid_post_o <= 0 and data_post_o holds.
- Latency and throughput: 1 cycle from input accept to valid_post_o; 1 beat/cycle when downstream is always ready.
- Output stability: while valid_post_o=1 and ready_post_i=0, valid_post_o and data_post_o hold unchanged.
- FSM, evaluated only on an accept of g:
  - g == owner and cnt+1 < BURST: stay LOCKED, cnt++.
  - Otherwise, if BURST>1 and g != owner: LOCKED(g), cnt=1.
  - Otherwise (cnt reached BURST, or BURST==1): IDLE, cnt=0, ptr=(g+1) mod N.
  - On every accept that leaves LOCKED or occurs in IDLE, ptr=(g+1) mod N.
- Owner drops valid while LOCKED: the next accept goes to another requester per the search; the FSM re-locks to that requester with cnt=1.
- No accept in a cycle: FSM, cnt and ptr hold.
- Fairness: a continuously valid requester is accepted within (N-1)*BURST accepts.
- Requester contract: a sender keeps valid and data stable until its ready is seen. The arbiter does not check this.
- Simultaneous requests: the requester nearest ptr (mod N) wins; ties are impossible.

Optional Feature:
- Macro: HS_ARB_SRC_ID_EN.
- Defined: adds output port src_id_o, width $clog2(N), registered alongside data_post_o. It holds the index of the requester that supplied the current beat, resets to 0, and follows the same hold rules as the data.
- Undefined: the port and its register are absent; behaviour is otherwise identical.

Decomposition:
- Package hs_pkg: typedef arb_state_e {IDLE, LOCKED}; function rr_next(ptr, N); localparam IDW = $clog2(N) computed in the module from N.
- Sub-module hs_rr_pick: combinational one-hot first-valid search from a start index.
  - Inputs: req[N], start.
  - Outputs: gnt_onehot, gnt_idx, any.
  - Instantiated once; the arbiter forces start=owner when LOCKED and the owner is valid.

Test Plan (N=4, W=8, BURST=2 unless noted):
- Reset check: assert rst for 3 cycles with all valid_pre_i=1 -> valid_post_o=0 and data_post_o=0 during reset; ready_pre_o=0; the first beat after reset comes from requester 0.
- All four requesters always valid with data 0x10+k, ready_post_i=1 -> output order 0,0,1,1,2,2,3,3,0,... at one beat per cycle, 1-cycle latency.
- Downstream backpressure: ready_post_i=0 for 5 cycles while valid_post_o=1 carries 0x21 -> data_post_o stays 0x21, all ready_pre_o=0, no beat lost or duplicated once ready returns.
- Burst break: only requester 2 valid for 1 beat, then requesters 2 and 3 both valid -> order 2, 2, 3, 3, 2 (count resets on re-lock).
- BURST=1, requesters 1 and 3 valid, random 50% stalls on ready_post_i over 200 cycles -> strict alternation 1,3,1,3; scoreboard confirms every sent byte is received in order per requester.
- HS_ARB_SRC_ID_EN defined, same stimulus as the second test -> src_id_o matches the requester index on every valid_post_o beat, and is 0 after reset.
